// File: rtl/div_unit_if.sv
// ---------------------------------------------------------------------------
// div_unit_if
//   Request/result bundle between the execute stage and the multi-cycle
//   divider.
//
//   Requester -> divider : start_i, signed_i, a_i, b_i, cancel_i
//   Divider -> requester : busy_o, valid_o, hi_o, lo_o, dbz_o
//
//   Modports:
//     master - the execute stage / hazard logic driving requests
//     slave  - the divider itself
// ---------------------------------------------------------------------------
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cancel_i;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             dbz_o;

  modport master (
    output start_i, signed_i, a_i, b_i, cancel_i,
    input  busy_o, valid_o, hi_o, lo_o, dbz_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, cancel_i,
    output busy_o, valid_o, hi_o, lo_o, dbz_o
  );
endinterface

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Multi-cycle radix-2 restoring divider for DIV/DIVU. One quotient bit is
//   produced per cycle over WIDTH iterations; the result is sign-corrected
//   and registered in a final DONE cycle, then announced with a one-cycle
//   valid_o pulse. A zero divisor skips the iterations entirely.
//
//   Ports:
//     clk  - pipeline clock, rising edge
//     rst  - asynchronous, active-low reset
//     bus  - div_unit_if.slave:
//              start_i/signed_i/a_i/b_i  request, sampled while idle
//              cancel_i                  abort, wins over everything but reset
//              busy_o                    operation in progress
//              valid_o                   one-cycle result strobe
//              hi_o/lo_o                 remainder/quotient, held
//              dbz_o                     divisor was zero, held with results
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_q;        // quotient shift register (dividend on entry)
  logic [WIDTH-1:0] r_r;        // partial remainder
  logic [WIDTH-1:0] r_d;        // divisor magnitude
  logic [5:0]       r_cnt;
  logic             r_negq;
  logic             r_negr;
  logic             r_dbz_pend; // DONE was reached via the zero-divisor path

  logic             r_valid;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;

  logic             w_start;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_rs;       // {R,Q} shifted left, upper WIDTH+1 bits
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_r_next;

  assign w_start  = bus.start_i && !bus.cancel_i;
  assign w_b_zero = (bus.b_i == '0);

  // Magnitudes only for signed requests; DIVU operands pass through raw.
  assign w_abs_a = (bus.signed_i && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
  assign w_abs_b = (bus.signed_i && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;

  // Restoring step. The shifted remainder can exceed WIDTH bits, hence the
  // WIDTH+1 subtract; the trial's MSB set means the divisor did not fit.
  assign w_rs     = {r_r, r_q[WIDTH-1]};
  assign w_trial  = w_rs - {1'b0, r_d};
  assign w_r_next = w_trial[WIDTH] ? w_rs[WIDTH-1:0] : w_trial[WIDTH-1:0];

  // NOTE: always_ff uses non-blocking (<=) so every register samples the
  // pre-edge values of the others; blocking here would chain them in order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: w_next gets its default before any branch so that no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    if (bus.cancel_i) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_start) w_next = w_b_zero ? S_DONE : S_BUSY;
        S_BUSY: if (r_cnt == LAST_STEP) w_next = S_DONE;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // NOTE: the datapath registers are reset too, not just the FSM, because
  // hi_o/lo_o/dbz_o must read zero straight out of reset, even mid-division.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q        <= '0;
      r_r        <= '0;
      r_d        <= '0;
      r_cnt      <= '0;
      r_negq     <= 1'b0;
      r_negr     <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_valid    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!bus.cancel_i) begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.start_i) begin
              r_r        <= '0;
              r_cnt      <= '0;
              r_dbz_pend <= w_b_zero;
              // Zero divisor keeps the raw dividend; it becomes hi_o as-is.
              r_q        <= w_b_zero ? bus.a_i : w_abs_a;
              r_d        <= w_abs_b;
              r_negq     <= bus.signed_i && (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
              r_negr     <= bus.signed_i && bus.a_i[WIDTH-1];
            end
          end
          S_BUSY: begin
            r_r   <= w_r_next;
            r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
            r_cnt <= r_cnt + 6'd1;
          end
          S_DONE: begin
            r_valid <= 1'b1;
            if (r_dbz_pend) begin
              r_lo  <= '1;
              r_hi  <= r_q;
              r_dbz <= 1'b1;
            end else begin
              r_lo  <= r_negq ? -r_q : r_q;
              r_hi  <= r_negr ? -r_r : r_r;
              r_dbz <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy_o  = (r_state != S_IDLE);
  assign bus.valid_o = r_valid;
  assign bus.hi_o    = r_hi;
  assign bus.lo_o    = r_lo;
  assign bus.dbz_o   = r_dbz;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//   Directed bench for div_unit. Expected results are queued when a request
//   is issued and compared when valid_o appears, together with the latency
//   measured from the start edge.
// ---------------------------------------------------------------------------
module tb_div_unit;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   start_cyc;
  int   errors;
  int   checks;
  exp_t sb_q[$];
  logic [31:0] last_lo;
  logic [31:0] last_hi;
  logic        last_dbz;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: request is sampled at the next rising edge,
  // and the task returns at the falling edge after it.
  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi, input logic edbz);
    exp_t e;
    e.lo = elo; e.hi = ehi; e.dbz = edbz;
    sb_q.push_back(e);
    bus.start_i  = 1'b1;
    bus.signed_i = s;
    bus.a_i      = a;
    bus.b_i      = b;
    @(negedge clk);
    start_cyc    = cyc;
    bus.start_i  = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int lat);
    exp_t e;
    int   n;
    n = 0;
    while (!bus.valid_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.valid_o) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else if (sb_q.size() == 0) begin
      check({tag, "_unexpected_valid"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_latency"}, 32'(cyc - start_cyc), 32'(lat));
      check({tag, "_lo"},  bus.lo_o, e.lo);
      check({tag, "_hi"},  bus.hi_o, e.hi);
      check({tag, "_dbz"}, {31'd0, bus.dbz_o}, {31'd0, e.dbz});
      last_lo  = e.lo;
      last_hi  = e.hi;
      last_dbz = e.dbz;
    end
  endtask

  initial begin
    int vcount;
    cyc          = 0;
    errors       = 0;
    checks       = 0;
    last_lo      = '0;
    last_hi      = '0;
    last_dbz     = 1'b0;
    rst          = 1'b0;
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.a_i      = '0;
    bus.b_i      = '0;
    bus.cancel_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",  {31'd0, bus.busy_o},  32'd0);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_lo",    bus.lo_o, 32'd0);
    check("rst_hi",    bus.hi_o, 32'd0);
    check("rst_dbz",   {31'd0, bus.dbz_o},   32'd0);
    rst = 1'b1;
    @(negedge clk);

    // DIVU 100 / 7
    start_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    check("divu_busy_run", {31'd0, bus.busy_o}, 32'd1);
    wait_result("divu_100_7", 33);
    @(negedge clk);
    check("divu_busy_after",  {31'd0, bus.busy_o},  32'd0);
    check("divu_valid_pulse", {31'd0, bus.valid_o}, 32'd0);

    // Signed cases
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    wait_result("div_neg_a", 33);
    @(negedge clk);
    start_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    wait_result("div_neg_b", 33);
    @(negedge clk);
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    wait_result("div_ovf", 33);
    @(negedge clk);

    // Unsigned large operands
    start_op(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0);
    wait_result("divu_large", 33);
    @(negedge clk);

    // Zero divisor, unsigned then signed (hi is raw dividend)
    start_op(1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    wait_result("dbz_u", 1);
    @(negedge clk);
    check("dbz_busy_after", {31'd0, bus.busy_o}, 32'd0);
    start_op(1'b1, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1);
    wait_result("dbz_s", 1);
    @(negedge clk);

    // Cancel at E10, restart at E12
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.a_i      = 32'd50;
    bus.b_i      = 32'd5;
    @(negedge clk);
    bus.start_i  = 1'b0;
    repeat (9) @(negedge clk);
    bus.cancel_i = 1'b1;
    @(negedge clk);
    bus.cancel_i = 1'b0;
    check("cancel_busy",  {31'd0, bus.busy_o},  32'd0);
    check("cancel_valid", {31'd0, bus.valid_o}, 32'd0);
    check("cancel_lo_hold", bus.lo_o, last_lo);
    check("cancel_hi_hold", bus.hi_o, last_hi);
    check("cancel_dbz_hold", {31'd0, bus.dbz_o}, {31'd0, last_dbz});
    @(negedge clk);
    check("cancel_valid_late", {31'd0, bus.valid_o}, 32'd0);
    start_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    wait_result("after_cancel", 33);

    // Cancel together with start in IDLE: start dropped
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.cancel_i = 1'b1;
    bus.a_i      = 32'd77;
    bus.b_i      = 32'd7;
    @(negedge clk);
    bus.start_i  = 1'b0;
    bus.cancel_i = 1'b0;
    check("cancel_start_busy", {31'd0, bus.busy_o}, 32'd0);

    // Back-to-back: new start in the valid_o cycle, mid-run start ignored
    start_op(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0);
    wait_result("b2b_first", 33);
    start_op(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);
    check("b2b_busy",  {31'd0, bus.busy_o},  32'd1);
    check("b2b_valid", {31'd0, bus.valid_o}, 32'd0);
    repeat (5) @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i     = 32'd100;
    bus.b_i     = 32'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_result("b2b_second", 33);
    @(negedge clk);

    // Asynchronous reset at iteration 20
    start_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    void'(sb_q.pop_back());
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_busy",  {31'd0, bus.busy_o},  32'd0);
    check("arst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("arst_lo",    bus.lo_o, 32'd0);
    check("arst_hi",    bus.hi_o, 32'd0);
    check("arst_dbz",   {31'd0, bus.dbz_o},   32'd0);
    @(negedge clk);
    rst = 1'b1;
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o) vcount++;
    end
    check("arst_no_valid", 32'(vcount), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for DIV/DIVU, operating alongside the ALU in the execute stage. It takes the forwarded execute-stage operands, runs a radix-2 restoring division over 32 iterations, and returns {remainder, quotient} for the HI/LO path that feeds the memory-stage HI/LO pipeline register. While it runs, the hazard unit holds the front of the pipeline stalled using `busy_o`.

## Interface
- `WIDTH`, 32, operand and result width; iteration count equals WIDTH.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request a division; sampled only while `busy_o`=0.
- `signed_i`  in  1  1=DIV (two's complement), 0=DIVU; sampled with `start_i`.
- `a_i`  in  WIDTH  dividend; sampled with `start_i`.
- `b_i`  in  WIDTH  divisor; sampled with `start_i`.
- `cancel_i`  in  1  abort (execute flush); overrides everything except reset.
- `busy_o`  out  1  division in progress (states BUSY, DONE).
- `valid_o`  out  1  one-cycle pulse; `hi_o`/`lo_o` carry a new result.
- `hi_o`  out  WIDTH  remainder; held until the next `valid_o`.
- `lo_o`  out  WIDTH  quotient; held until the next `valid_o`.
- `dbz_o`  out  1  divisor was zero; qualified by `valid_o`, held with the results.

## Operation
- The FSM has three states: IDLE, BUSY, DONE. Reset enters IDLE.
- **IDLE, `start_i`=1, `cancel_i`=0, `b_i`≠0.**
  - Latch |a| into the quotient shift register and |b| into the divisor register. Magnitudes are taken only when `signed_i`=1; otherwise the raw values are latched.
  - Clear the partial remainder and the 6-bit counter.
  - Save `negq` = a[31]^b[31] and `negr` = a[31], both gated by `signed_i`.
  - Next state is BUSY.
- **IDLE, `start_i`=1, `cancel_i`=0, `b_i`=0.**
  - Next state is DONE with the zero-divisor flag set. No iterations run.
- **BUSY, one step per cycle.**
  - Form {R,Q} <<= 1, then compute trial = R − D using a (WIDTH+1)-bit subtract.
  - If trial ≥ 0: R = trial and Q[0] = 1. Otherwise R is unchanged and Q[0] = 0.
  - Increment the counter. After step WIDTH (counter = WIDTH−1 before the step), the next state is DONE.
- **DONE, one cycle.**
  - Register `lo_o` = negq ? −Q : Q and `hi_o` = negr ? −R : R.
  - Assert `valid_o` for the following cycle. Next state is IDLE.
- **Zero divisor.** `lo_o` = 32'hFFFFFFFF, `hi_o` = a_i as latched (raw, no sign correction), `dbz_o` = 1.
- **Overflow case.** Signed 0x80000000 / −1 gives `lo_o` = 0x80000000 and `hi_o` = 0. This falls out of the magnitude arithmetic; no special case is needed.
- **Cancel.**
  - In any state, `cancel_i`=1 forces IDLE at the next edge.
  - No `valid_o` is produced for the aborted operation. `hi_o`, `lo_o` and `dbz_o` are unchanged.
  - When `start_i` and `cancel_i` are both high in IDLE, cancel wins and the start is dropped.
- **Start while busy.** `start_i` is ignored while `busy_o`=1. Operands are not re-sampled.
- **Back-to-back.** In the cycle where `valid_o`=1, `busy_o`=0, so a new `start_i` is accepted in that same cycle.

## Timing
- **Reset values.** `busy_o`=0, `valid_o`=0, `hi_o`=0, `lo_o`=0, `dbz_o`=0, state IDLE, all internal registers 0. Reset is asynchronous and takes effect immediately, including mid-division.
- **Normal division, counting start sampled at edge E0.**
  - `busy_o` is high from after E0 until after E33.
  - Iterations run at edges E1 to E32. The DONE output update happens at edge E33.
  - `valid_o` is high from E33 to E34.
  - Latency is 33 edges from the start edge to the result edge.
- **Zero divisor.** `busy_o` is high from after E0 until after E1. Results and `valid_o` are registered at E1, so latency is 1 edge.
- **Output form.** All outputs are registered; there is no combinational path from any input to any output.
- **Hazard unit use.** The hazard unit ORs `busy_o` with (`start_i` & ~`busy_o`) to stall F, D and E. The result is written to HI/LO in the cycle where `valid_o`=1.

## Test plan
- **Unsigned division.** DIVU 100 / 7 with start at E0 → `valid_o` at E33 with `lo_o`=14, `hi_o`=2, `dbz_o`=0. `busy_o` is low one cycle later.
- **Signed negative dividend.** DIV −7 / 2 (0xFFFFFFF9 / 2) → `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF.
- **Signed negative divisor.** DIV 7 / −2 → `lo_o`=0xFFFFFFFD, `hi_o`=1.
- **Signed overflow.** DIV 0x80000000 / 0xFFFFFFFF → `lo_o`=0x80000000, `hi_o`=0.
- **Unsigned large operands.** DIVU 0xFFFFFFFF / 0x10 → `lo_o`=0x0FFFFFFF, `hi_o`=0xF.
- **Zero divisor.** DIVU 0x1234 / 0 → `valid_o` at E1 with `lo_o`=0xFFFFFFFF, `hi_o`=0x1234, `dbz_o`=1.
- **Cancel mid-operation.** Start DIVU 50/5, pulse `cancel_i` at E10 → `busy_o`=0 after E10, no `valid_o`, `hi_o`/`lo_o` keep their previous values.
  - A new start of 9/3 at E12 → `lo_o`=3, `hi_o`=0 at E45.
- **Back-to-back and reset.**
  - Assert `start_i` (DIVU 9/4) in the `valid_o` cycle of a prior op → accepted; result `lo_o`=2, `hi_o`=1 arrives 33 edges later.
  - A second `start_i` pulsed mid-run is ignored.
  - Asserting `rst` low at iteration 20 → all outputs 0 immediately, and no `valid_o` after release.
